// File: rtl/pe_request_agent.sv
// pe_request_agent
// Requester-side agent for one processing element on the shared accumulator
// bus. Partial sums from the element are buffered in a small FIFO. While the
// FIFO holds data the agent raises req toward the round-robin arbiter. On
// grant it streams a bounded burst of up to MAX_BURST words. It then releases
// req for at least one cycle so that the arbiter can rotate priority.
//
// Ports:
//   clk        - single clock, all state updates on posedge
//   rst_n      - asynchronous active-low reset
//   in_valid   - element offers in_data this cycle
//   in_data    - partial-sum word from the element
//   in_ready   - FIFO can accept a word (occupancy below FIFO_DEPTH)
//   req        - registered request to the arbiter
//   grant      - this agent's grant bit from the arbiter
//   bus_valid  - bus_data is being transferred this cycle
//   bus_data   - FIFO head word (meaningless while bus_valid is low)
//   fifo_count - current FIFO occupancy
module pe_request_agent #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          in_ready,
    output logic                          req,
    input  logic                          grant,
    output logic                          bus_valid,
    output logic [DATA_WIDTH-1:0]         bus_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic [BW-1:0]         burst_len_q, burst_len_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  push_s;
    logic                  pop_s;

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign in_ready   = (count_q != CW'(FIFO_DEPTH));
    // Transfer only while in XFER and the arbiter still grants us.
    assign bus_valid  = (state_q == ST_XFER) & grant;
    assign push_s     = in_valid & in_ready;
    assign pop_s      = bus_valid;
    assign bus_data   = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign req        = req_q;

    // FIFO pointer and occupancy next-state; power-of-two depth wraps naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Request FSM next-state, burst length latch and beat counter.
    always_comb begin
        state_d     = state_q;
        burst_len_d = burst_len_q;
        beat_d      = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != CW'(0)) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (grant) begin
                    // Only words present now belong to this burst.
                    state_d = ST_XFER;
                    beat_d  = BW'(0);
                    if (count_q > CW'(MAX_BURST)) begin
                        burst_len_d = BW'(MAX_BURST);
                    end else begin
                        burst_len_d = BW'(count_q);
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_XFER: begin
                if (grant) begin
                    beat_d = beat_q + BW'(1);
                    if ((beat_q + BW'(1)) == burst_len_q) begin
                        state_d = ST_REL;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    // Arbiter withdrew: keep asking, remaining words stay queued.
                    state_d = ST_REQ;
                end
            end
            ST_REL: begin
                if (!grant) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d = (state_d == ST_REQ) || (state_d == ST_XFER);
    end

    // Control and pointer registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= PW'(0);
            rd_ptr_q    <= PW'(0);
            count_q     <= CW'(0);
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            burst_len_q <= BW'(0);
            beat_q      <= BW'(0);
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            req_q       <= req_d;
            burst_len_q <= burst_len_d;
            beat_q      <= beat_d;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
